mask_data_credit_ctrl: RTL and testbench
========================================

// Module: mask_data_credit_ctrl
// PURPOSE
// Credit/space controller for the mask_data trimming pipeline. Tracks free bytes in the downstream
// buffer and drives mask_data's bytesavailin. Reserves space at issue time, so the 4-cycle
// in-flight window can never over-commit. Also checks mask_data output against the reservation,
// counts dropped bytes, and sequences a drain/restore flush.
// PARAMETERS
// BUSBYTEWIDTH  16  bytes per bus beat; keep width
// BYTESAVAIL    32  downstream buffer capacity in bytes
// MASKLATENCY   4   cycles from businvld at mask_data input to busoutvld
// DROPW         32  dropcount width
// (AW = $clog2(BYTESAVAIL), CW = $clog2(BYTESAVAIL+1))
// PORTS
// clk            in   1             clock
// reset          in   1             asynchronous, active-low reset
// businvld       in   1             beat presented to mask_data this cycle
// businkeep      in   BUSBYTEWIDTH  keep of that beat
// bytesavailout  out  AW            to mask_data bytesavailin, same cycle as businvld
// busoutvld      in   1             mask_data output valid
// busoutkeep     in   BUSBYTEWIDTH  mask_data output keep
// rdvld          in   1             downstream freed bytes this cycle
// rdbytes        in   CW            number of bytes freed
// flush          in   1             request drain and credit restore
// flushdone      out  1             1-cycle pulse, credits restored
// credits        out  CW            current free-byte count (register)
// dropcount      out  DROPW         saturating count of trimmed bytes
// mismatch       out  1             sticky: output keep disagrees with reservation
// overflowerr    out  1             sticky: return would exceed BYTESAVAIL
// BEHAVIOUR
// - Reset (async assert, sync release): credits=BYTESAVAIL, state=RUN, dropcount=0; flushdone,
//   mismatch and overflowerr =0; delay line cleared. Reset mid-flush abandons the flush.
// - bytesavailout = (state==RUN) ? min(credits, BYTESAVAIL-1) : 0. This is a function of flops
//   only, with no input-to-output path. It saturates because the AW field cannot encode BYTESAVAIL.
// - pop = popcount(businkeep). reserve = (businvld && RUN) ? min(pop, bytesavailout) : 0.
// - credits_next = credits - reserve + (rdvld ? rdbytes : 0). Issue and return on the same cycle
//   both apply. If the sum exceeds BYTESAVAIL, clamp to BYTESAVAIL and set overflowerr.
// - dropcount += pop - reserve on every businvld, in any state. It saturates at all-ones.
// - Delay line: MASKLATENCY-deep shift of {businvld, reserve}. Each cycle, compare the tail
//   against {busoutvld, popcount(busoutkeep)}. On any difference, set mismatch (sticky until reset).
// - FSM:
//   RUN: flush -> DRAIN, counter := MASKLATENCY-1.
//   DRAIN: bytesavailout=0, so reserve=0. rdvld is still applied. At counter==0 -> RESTORE.
//          flush is ignored while in DRAIN.
//   RESTORE: credits := BYTESAVAIL (rdvld ignored this cycle), flushdone=1 -> RUN.
//   flush asserted in RESTORE is ignored; it must be re-asserted in RUN.
// - Latency: credits and dropcount update 1 cycle after the event. flushdone fires
//   MASKLATENCY+1 cycles after flush is sampled.
// - credits never wraps below 0, because reserve <= credits by construction.
// STRUCTURE
// - mask_data_pkg: state enum {RUN, DRAIN, RESTORE}, AW/CW width functions, popcount function.
// - Sub-module keep_popcount (BUSBYTEWIDTH -> $clog2(BUSBYTEWIDTH+1)), instanced twice
//   (issue side and check side).
// - The rest is one module: credit register, delay line, FSM, counters.
// TESTING
// 1 Reset released: credits=32, bytesavailout=31, dropcount=0, all flags 0.
// 2 businvld, keep=16'hFFFF for 3 cycles, no rdvld: reserves 16,16,0. credits 32->16->0.
//   dropcount=16, bytesavailout=0.
// 3 credits=0, same cycle businvld keep=16'h00FF and rdvld rdbytes=8: reserve 0, credits=8,
//   dropcount+=8.
// 4 credits=32, rdvld rdbytes=1: credits stays 32, overflowerr=1 and stays set.
// 5 Reserve 4 (keep 16'h000F, avail>=4). Drive busoutvld with keep=16'h001F 4 cycles later:
//   mismatch=1. With keep=16'h000F: mismatch stays 0.
// 6 credits=3, pulse flush: bytesavailout=0 next cycle, businvld keep=16'h0003 in DRAIN adds 2
//   to dropcount. flushdone pulses 5 cycles after flush, credits=32, bytesavailout=31.

Source files
------------

// File: rtl/mask_data_credit_ctrl_pkg.sv
// Shared types and width helpers for the mask_data credit controller.
// Includes the FSM state type and a generic popcount over a zero-extended keep vector.
package mask_data_credit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_RESTORE
  } state_e;

  localparam int unsigned POPCOUNT_MAXW = 64;

  function automatic int unsigned addr_width(input int unsigned bytes);
    return $clog2(bytes);
  endfunction

  function automatic int unsigned count_width(input int unsigned bytes);
    return $clog2(bytes + 1);
  endfunction

  function automatic int unsigned popcount(input logic [POPCOUNT_MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POPCOUNT_MAXW; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mask_data_credit_ctrl_if.sv
// Issue, check, return and flush signals between mask_data glue and the credit controller.
// The master modport belongs to the environment; the slave modport belongs to the controller.
interface mask_data_credit_ctrl_if
  import mask_data_credit_ctrl_pkg::*;
#(
  parameter int unsigned BUSBYTEWIDTH = 16,
  parameter int unsigned BYTESAVAIL   = 32,
  parameter int unsigned DROPW        = 32
);
  localparam int unsigned AW = addr_width(BYTESAVAIL);
  localparam int unsigned CW = count_width(BYTESAVAIL);

  logic                    businvld;
  logic [BUSBYTEWIDTH-1:0] businkeep;
  logic [AW-1:0]           bytesavailout;
  logic                    busoutvld;
  logic [BUSBYTEWIDTH-1:0] busoutkeep;
  logic                    rdvld;
  logic [CW-1:0]           rdbytes;
  logic                    flush;
  logic                    flushdone;
  logic [CW-1:0]           credits;
  logic [DROPW-1:0]        dropcount;
  logic                    mismatch;
  logic                    overflowerr;

  modport master (
    output businvld, businkeep, busoutvld, busoutkeep, rdvld, rdbytes, flush,
    input  bytesavailout, flushdone, credits, dropcount, mismatch, overflowerr
  );

  modport slave (
    input  businvld, businkeep, busoutvld, busoutkeep, rdvld, rdbytes, flush,
    output bytesavailout, flushdone, credits, dropcount, mismatch, overflowerr
  );

endinterface

// File: rtl/mask_data_credit_ctrl_keep_popcount.sv
// Counts set bits in a keep vector; used for both the issued beat and the mask_data output.
module keep_popcount
  import mask_data_credit_ctrl_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned PW = count_width(W)
) (
  input  logic [W-1:0]  keep,
  output logic [PW-1:0] count
);

  logic [POPCOUNT_MAXW-1:0] keep_ext;

  always_comb begin
    keep_ext        = '0;
    keep_ext[W-1:0] = keep;
    count           = PW'(popcount(keep_ext));
  end

endmodule

// File: rtl/mask_data_credit_ctrl.sv
// Credit controller for mask_data: reserves downstream space at issue, checks the trimmed
// output against that reservation, counts dropped bytes and sequences a drain/restore flush.
module mask_data_credit_ctrl
  import mask_data_credit_ctrl_pkg::*;
#(
  parameter int unsigned BUSBYTEWIDTH = 16,
  parameter int unsigned BYTESAVAIL   = 32,
  parameter int unsigned MASKLATENCY  = 4,
  parameter int unsigned DROPW        = 32
) (
  input logic                    clk,
  input logic                    reset,
  mask_data_credit_ctrl_if.slave bus
);

  localparam int unsigned AW   = addr_width(BYTESAVAIL);
  localparam int unsigned CW   = count_width(BYTESAVAIL);
  localparam int unsigned PW   = count_width(BUSBYTEWIDTH);
  localparam int unsigned RW   = (PW > CW) ? PW : CW;
  localparam int unsigned SW   = RW + 1;
  localparam int unsigned DSW  = DROPW + 1;
  localparam int unsigned CNTW = (MASKLATENCY > 1) ? $clog2(MASKLATENCY) : 1;

  state_e                           state_q, state_d;
  logic [CNTW-1:0]                  cnt_q, cnt_d;
  logic [CW-1:0]                    credits_q, credits_d;
  logic [DROPW-1:0]                 dropcount_q, dropcount_d;
  logic                             flushdone_q, flushdone_d;
  logic                             mismatch_q, mismatch_d;
  logic                             overflow_q, overflow_d;
  logic [MASKLATENCY-1:0]           dly_vld_q, dly_vld_d;
  logic [MASKLATENCY-1:0][PW-1:0]   dly_res_q, dly_res_d;

  logic [PW-1:0]  pop_in, pop_out;
  logic [AW-1:0]  avail;
  logic [RW-1:0]  pop_r, avail_r, reserve;
  logic [SW-1:0]  credit_sum;
  logic [DSW-1:0] drop_sum;

  keep_popcount #(.W(BUSBYTEWIDTH), .PW(PW)) u_pop_issue (
    .keep  (bus.businkeep),
    .count (pop_in)
  );

  keep_popcount #(.W(BUSBYTEWIDTH), .PW(PW)) u_pop_check (
    .keep  (bus.busoutkeep),
    .count (pop_out)
  );

  // Advertised space comes from flops only; it saturates because AW cannot encode BYTESAVAIL.
  always_comb begin
    avail = '0;
    if (state_q == ST_RUN) begin
      if (credits_q > CW'(BYTESAVAIL - 1)) begin
        avail = AW'(BYTESAVAIL - 1);
      end else begin
        avail = AW'(credits_q);
      end
    end
  end

  always_comb begin
    pop_r   = RW'(pop_in);
    avail_r = RW'(avail);
    reserve = '0;
    if (bus.businvld && (state_q == ST_RUN)) begin
      reserve = (pop_r < avail_r) ? pop_r : avail_r;
    end

    credit_sum = SW'(credits_q) - SW'(reserve) + (bus.rdvld ? SW'(bus.rdbytes) : '0);
    credits_d  = credits_q;
    overflow_d = overflow_q;
    if (state_q == ST_RESTORE) begin
      credits_d = CW'(BYTESAVAIL);
    end else if (credit_sum > SW'(BYTESAVAIL)) begin
      credits_d  = CW'(BYTESAVAIL);
      overflow_d = 1'b1;
    end else begin
      credits_d = CW'(credit_sum);
    end

    drop_sum    = {1'b0, dropcount_q} + DSW'(pop_r - reserve);
    dropcount_d = dropcount_q;
    if (bus.businvld) begin
      dropcount_d = drop_sum[DROPW] ? '1 : drop_sum[DROPW-1:0];
    end
  end

  // The tail of the delay line lines up with what mask_data should emit this cycle.
  always_comb begin
    dly_vld_d[0] = bus.businvld;
    dly_res_d[0] = PW'(reserve);
    for (int unsigned i = 1; i < MASKLATENCY; i++) begin
      dly_vld_d[i] = dly_vld_q[i-1];
      dly_res_d[i] = dly_res_q[i-1];
    end
    mismatch_d = mismatch_q
               | (dly_vld_q[MASKLATENCY-1] != bus.busoutvld)
               | (dly_res_q[MASKLATENCY-1] != pop_out);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flushdone_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_DRAIN;
          cnt_d   = CNTW'(MASKLATENCY - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_RESTORE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESTORE: begin
        state_d     = ST_RUN;
        flushdone_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      credits_q   <= CW'(BYTESAVAIL);
      dropcount_q <= '0;
      flushdone_q <= 1'b0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      dly_vld_q   <= '0;
      dly_res_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      credits_q   <= credits_d;
      dropcount_q <= dropcount_d;
      flushdone_q <= flushdone_d;
      mismatch_q  <= mismatch_d;
      overflow_q  <= overflow_d;
      dly_vld_q   <= dly_vld_d;
      dly_res_q   <= dly_res_d;
    end
  end

  assign bus.bytesavailout = avail;
  assign bus.flushdone     = flushdone_q;
  assign bus.credits       = credits_q;
  assign bus.dropcount     = dropcount_q;
  assign bus.mismatch      = mismatch_q;
  assign bus.overflowerr   = overflow_q;

endmodule

// File: tb/tb_mask_data_credit_ctrl.sv
// Directed bench for mask_data_credit_ctrl; a 4-stage pipe stands in for mask_data's output.
module tb_mask_data_credit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        mvld;
  logic [15:0] mkeep;
  logic [3:0]        pvld;
  logic [3:0][15:0]  pkeep;

  mask_data_credit_ctrl_if #(.BUSBYTEWIDTH(16), .BYTESAVAIL(32), .DROPW(32)) bus ();

  mask_data_credit_ctrl #(
    .BUSBYTEWIDTH (16),
    .BYTESAVAIL   (32),
    .MASKLATENCY  (4),
    .DROPW        (32)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // What mask_data would emit, four cycles after the bench presents the matching input beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pvld  <= '0;
      pkeep <= '0;
    end else begin
      pvld  <= {pvld[2:0], mvld};
      pkeep <= {pkeep[2:0], mkeep};
    end
  end

  assign bus.busoutvld  = pvld[3];
  assign bus.busoutkeep = pkeep[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.businvld  = 1'b0;
    bus.businkeep = '0;
    bus.rdvld     = 1'b0;
    bus.rdbytes   = '0;
    bus.flush     = 1'b0;
    mvld          = 1'b0;
    mkeep         = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    checks++; if (bus.credits !== 6'd32) begin errors++; $display("FAIL reset_credits got %0d want 32", bus.credits); end
    checks++; if (bus.bytesavailout !== 5'd31) begin errors++; $display("FAIL reset_avail got %0d want 31", bus.bytesavailout); end
    checks++; if (bus.dropcount !== 32'd0) begin errors++; $display("FAIL reset_dropcount got %0d want 0", bus.dropcount); end
    checks++; if (bus.flushdone !== 1'b0) begin errors++; $display("FAIL reset_flushdone got %b want 0", bus.flushdone); end
    checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", bus.mismatch); end
    checks++; if (bus.overflowerr !== 1'b0) begin errors++; $display("FAIL reset_overflowerr got %b want 0", bus.overflowerr); end
  endtask

  task automatic test_issue();
    bus.businvld = 1'b1; bus.businkeep = 16'hFFFF; mvld = 1'b1; mkeep = 16'hFFFF;
    tick();
    checks++; if (bus.credits !== 6'd16) begin errors++; $display("FAIL issue1_credits got %0d want 16", bus.credits); end
    checks++; if (bus.bytesavailout !== 5'd16) begin errors++; $display("FAIL issue1_avail got %0d want 16", bus.bytesavailout); end
    tick();
    checks++; if (bus.credits !== 6'd0) begin errors++; $display("FAIL issue2_credits got %0d want 0", bus.credits); end
    checks++; if (bus.dropcount !== 32'd0) begin errors++; $display("FAIL issue2_dropcount got %0d want 0", bus.dropcount); end
    mkeep = 16'h0000;
    tick();
    idle_inputs();
    checks++; if (bus.credits !== 6'd0) begin errors++; $display("FAIL issue3_credits got %0d want 0", bus.credits); end
    checks++; if (bus.dropcount !== 32'd16) begin errors++; $display("FAIL issue3_dropcount got %0d want 16", bus.dropcount); end
    checks++; if (bus.bytesavailout !== 5'd0) begin errors++; $display("FAIL issue3_avail got %0d want 0", bus.bytesavailout); end
  endtask

  task automatic test_same_cycle();
    bus.businvld = 1'b1; bus.businkeep = 16'h00FF; mvld = 1'b1; mkeep = 16'h0000;
    bus.rdvld = 1'b1; bus.rdbytes = 6'd8;
    tick();
    idle_inputs();
    checks++; if (bus.credits !== 6'd8) begin errors++; $display("FAIL same_cycle_credits got %0d want 8", bus.credits); end
    checks++; if (bus.dropcount !== 32'd24) begin errors++; $display("FAIL same_cycle_dropcount got %0d want 24", bus.dropcount); end
    checks++; if (bus.bytesavailout !== 5'd8) begin errors++; $display("FAIL same_cycle_avail got %0d want 8", bus.bytesavailout); end
  endtask

  task automatic test_overflow();
    bus.rdvld = 1'b1; bus.rdbytes = 6'd24;
    tick();
    idle_inputs();
    checks++; if (bus.credits !== 6'd32) begin errors++; $display("FAIL fill_credits got %0d want 32", bus.credits); end
    checks++; if (bus.overflowerr !== 1'b0) begin errors++; $display("FAIL fill_overflowerr got %b want 0", bus.overflowerr); end
    checks++; if (bus.bytesavailout !== 5'd31) begin errors++; $display("FAIL fill_avail got %0d want 31", bus.bytesavailout); end
    bus.rdvld = 1'b1; bus.rdbytes = 6'd1;
    tick();
    idle_inputs();
    checks++; if (bus.credits !== 6'd32) begin errors++; $display("FAIL overflow_credits got %0d want 32", bus.credits); end
    checks++; if (bus.overflowerr !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", bus.overflowerr); end
    tick();
    checks++; if (bus.overflowerr !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b want 1", bus.overflowerr); end
  endtask

  task automatic test_mismatch_clean();
    bus.businvld = 1'b1; bus.businkeep = 16'h000F; mvld = 1'b1; mkeep = 16'h000F;
    tick();
    idle_inputs();
    checks++; if (bus.credits !== 6'd28) begin errors++; $display("FAIL clean_credits got %0d want 28", bus.credits); end
    bus.rdvld = 1'b1; bus.rdbytes = 6'd4;
    tick();
    idle_inputs();
    repeat (4) tick();
    checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL clean_mismatch got %b want 0", bus.mismatch); end
    checks++; if (bus.credits !== 6'd32) begin errors++; $display("FAIL clean_return_credits got %0d want 32", bus.credits); end
  endtask

  task automatic test_flush();
    bus.businvld = 1'b1; bus.businkeep = 16'hFFFF; mvld = 1'b1; mkeep = 16'hFFFF;
    tick();
    bus.businkeep = 16'h1FFF; mkeep = 16'h1FFF;
    tick();
    idle_inputs();
    checks++; if (bus.credits !== 6'd3) begin errors++; $display("FAIL preflush_credits got %0d want 3", bus.credits); end
    checks++; if (bus.bytesavailout !== 5'd3) begin errors++; $display("FAIL preflush_avail got %0d want 3", bus.bytesavailout); end
    bus.flush = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.bytesavailout !== 5'd0) begin errors++; $display("FAIL drain_avail got %0d want 0", bus.bytesavailout); end
    checks++; if (bus.flushdone !== 1'b0) begin errors++; $display("FAIL drain1_flushdone got %b want 0", bus.flushdone); end
    bus.businvld = 1'b1; bus.businkeep = 16'h0003; mvld = 1'b1; mkeep = 16'h0000;
    bus.rdvld = 1'b1; bus.rdbytes = 6'd1;
    tick();
    idle_inputs();
    checks++; if (bus.dropcount !== 32'd26) begin errors++; $display("FAIL drain_dropcount got %0d want 26", bus.dropcount); end
    checks++; if (bus.credits !== 6'd4) begin errors++; $display("FAIL drain_return_credits got %0d want 4", bus.credits); end
    tick();
    tick();
    checks++; if (bus.flushdone !== 1'b0) begin errors++; $display("FAIL drain4_flushdone got %b want 0", bus.flushdone); end
    checks++; if (bus.bytesavailout !== 5'd0) begin errors++; $display("FAIL drain4_avail got %0d want 0", bus.bytesavailout); end
    tick();
    checks++; if (bus.flushdone !== 1'b0) begin errors++; $display("FAIL restore_flushdone got %b want 0", bus.flushdone); end
    bus.rdvld = 1'b1; bus.rdbytes = 6'd5; bus.flush = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.flushdone !== 1'b1) begin errors++; $display("FAIL flushdone_pulse got %b want 1", bus.flushdone); end
    checks++; if (bus.credits !== 6'd32) begin errors++; $display("FAIL restored_credits got %0d want 32", bus.credits); end
    checks++; if (bus.bytesavailout !== 5'd31) begin errors++; $display("FAIL restored_avail got %0d want 31", bus.bytesavailout); end
    tick();
    checks++; if (bus.flushdone !== 1'b0) begin errors++; $display("FAIL flushdone_single got %b want 0", bus.flushdone); end
    checks++; if (bus.bytesavailout !== 5'd31) begin errors++; $display("FAIL restore_flush_ignored_avail got %0d want 31", bus.bytesavailout); end
  endtask

  task automatic test_mismatch_detect();
    bus.businvld = 1'b1; bus.businkeep = 16'h000F; mvld = 1'b1; mkeep = 16'h001F;
    tick();
    idle_inputs();
    checks++; if (bus.credits !== 6'd28) begin errors++; $display("FAIL detect_credits got %0d want 28", bus.credits); end
    repeat (3) tick();
    checks++; if (bus.mismatch !== 1'b0) begin errors++; $display("FAIL detect_early_mismatch got %b want 0", bus.mismatch); end
    tick();
    checks++; if (bus.mismatch !== 1'b1) begin errors++; $display("FAIL detect_mismatch got %b want 1", bus.mismatch); end
    tick();
    checks++; if (bus.mismatch !== 1'b1) begin errors++; $display("FAIL detect_sticky got %b want 1", bus.mismatch); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_same_cycle();
    test_overflow();
    test_mismatch_clean();
    test_flush();
    test_mismatch_detect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
